apb_rr_master: RTL and testbench

- Shares one APB3 master port among NIN independent requesters using round-robin arbitration.
- Each requester presents a simple request/acknowledge transaction. The block sequences the APB setup and access phases and returns read data and error status to the granted requester.
- It sits in front of an APB slave or decoder. Its master-side outputs must satisfy every APB slave-facing bus property the team enforces, including stable PSEL, PENABLE and payload while stalled.

---
 rtl/apb_rr_master.sv | 174 +++++++++++++++++
 tb/tb_apb_rr_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// Round-robin arbiter sharing one APB3 master port among NIN requesters.
// Every output is a flop; the granted requester's payload is captured at grant
// and held on the bus until the slave completes the access.
`timescale 1ns/1ps
module apb_rr_master #(
  parameter int unsigned NIN = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [NIN-1:0]        i_req,
  input  logic [NIN*AW-1:0]     i_addr,
  input  logic [NIN-1:0]        i_write,
  input  logic [NIN*DW-1:0]     i_wdata,
  input  logic [NIN*DW/8-1:0]   i_wstrb,
  input  logic [NIN*3-1:0]      i_prot,
  output logic [NIN-1:0]        o_ack,
  output logic [DW-1:0]         o_rdata,
  output logic                  o_err,
  output logic [NIN-1:0]        o_grant,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [AW-1:0]         PADDR,
  output logic [DW-1:0]         PWDATA,
  output logic [DW/8-1:0]       PWSTRB,
  output logic [2:0]            PPROT,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DW-1:0]         PRDATA
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = (NIN > 1) ? $clog2(NIN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  last_q, last_d;
  logic           psel_q, psel_d;
  logic           penable_q, penable_d;
  logic           pwrite_q, pwrite_d;
  logic [AW-1:0]  paddr_q, paddr_d;
  logic [DW-1:0]  pwdata_q, pwdata_d;
  logic [SW-1:0]  pwstrb_q, pwstrb_d;
  logic [2:0]     pprot_q, pprot_d;
  logic [NIN-1:0] grant_q, grant_d;
  logic [NIN-1:0] ack_q, ack_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;

  logic [NIN-1:0] elig;
  logic           pick_vld;
  int unsigned    pick_n;
  int unsigned    cand;

  // Round-robin pick: first eligible requester searching upward from last+1,
  // masking any requester whose ack is currently on the output.
  always_comb begin
    elig     = i_req & ~ack_q;
    pick_vld = 1'b0;
    pick_n   = 0;
    cand     = 0;
    for (int unsigned k = 1; k <= NIN; k++) begin
      cand = (32'(last_q) + k) % NIN;
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_n   = cand;
      end
    end
  end

  // Next-state and registered-output logic for the setup/access sequencing.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwstrb_d  = pwstrb_q;
    pprot_d   = pprot_q;
    grant_d   = grant_q;
    ack_d     = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (pick_vld) begin
          paddr_d          = i_addr[pick_n*AW +: AW];
          pwrite_d         = i_write[pick_n];
          pwdata_d         = i_wdata[pick_n*DW +: DW];
          pwstrb_d         = i_write[pick_n] ? i_wstrb[pick_n*SW +: SW] : '0;
          pprot_d          = i_prot[pick_n*3 +: 3];
          psel_d           = 1'b1;
          grant_d          = '0;
          grant_d[pick_n]  = 1'b1;
          last_d           = PW'(pick_n);
          state_d          = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          ack_d     = grant_q;
          rdata_d   = pwrite_q ? '0 : PRDATA;
          err_d     = PSLVERR;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          grant_d   = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      last_q    <= PW'(NIN - 1);
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwstrb_q  <= '0;
      pprot_q   <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwstrb_q  <= pwstrb_d;
      pprot_q   <= pprot_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWSTRB  = pwstrb_q;
  assign PPROT   = pprot_q;
  assign o_grant = grant_q;
  assign o_ack   = ack_q;
  assign o_rdata = rdata_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference of the arbiter.
`timescale 1ns/1ps
module tb_apb_rr_master;

  localparam int NIN = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic [NIN-1:0]    i_req;
  logic [NIN*AW-1:0] i_addr;
  logic [NIN-1:0]    i_write;
  logic [NIN*DW-1:0] i_wdata;
  logic [NIN*SW-1:0] i_wstrb;
  logic [NIN*3-1:0]  i_prot;
  logic [NIN-1:0]    o_ack;
  logic [DW-1:0]     o_rdata;
  logic              o_err;
  logic [NIN-1:0]    o_grant;
  logic              PSEL, PENABLE, PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [SW-1:0]     PWSTRB;
  logic [2:0]        PPROT;
  logic              PREADY, PSLVERR;
  logic [DW-1:0]     PRDATA;

  apb_rr_master #(.NIN(NIN), .AW(AW), .DW(DW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .i_req(i_req), .i_addr(i_addr), .i_write(i_write), .i_wdata(i_wdata),
    .i_wstrb(i_wstrb), .i_prot(i_prot),
    .o_ack(o_ack), .o_rdata(o_rdata), .o_err(o_err), .o_grant(o_grant),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PWSTRB(PWSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference view of the bus: transfer in flight, its owner, its captured payload.
  bit             m_psel, m_pen, m_pwrite, m_err;
  logic [AW-1:0]  m_paddr;
  logic [DW-1:0]  m_pwdata, m_rdata;
  logic [SW-1:0]  m_pwstrb;
  logic [2:0]     m_pprot;
  logic [NIN-1:0] m_ack;
  int             m_owner, m_last;

  // Requester and slave behaviour knobs.
  int             remaining [NIN];
  int             stall;
  bit             rand_slave, scramble;
  logic [DW-1:0]  slv_rdata;
  logic           slv_err;

  // Observed grant history.
  logic [NIN-1:0] gq[$];
  int             gapq[$];
  int             idle_run;
  logic [NIN-1:0] prev_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_psel = 0; m_pen = 0; m_pwrite = 0; m_err = 0;
    m_paddr = '0; m_pwdata = '0; m_rdata = '0; m_pwstrb = '0; m_pprot = '0;
    m_ack = '0; m_owner = -1; m_last = NIN - 1;
  endtask

  task automatic rand_payload(input int i);
    i_addr[i*AW +: AW]  = $urandom;
    i_write[i]          = 1'($urandom_range(0, 1));
    i_wdata[i*DW +: DW] = $urandom;
    i_wstrb[i*SW +: SW] = SW'($urandom);
    i_prot[i*3 +: 3]    = 3'($urandom);
  endtask

  task automatic issue(input int i, input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input logic [2:0] p, input int extra);
    i_addr[i*AW +: AW]  = a;
    i_write[i]          = w;
    i_wdata[i*DW +: DW] = d;
    i_wstrb[i*SW +: SW] = s;
    i_prot[i*3 +: 3]    = p;
    i_req[i]            = 1'b1;
    remaining[i]        = extra;
  endtask

  // One clock: drive the slave, predict, clock, compare, let requesters react.
  task automatic step();
    bit             n_psel, n_pen, n_pwrite, n_err;
    logic [AW-1:0]  n_paddr;
    logic [DW-1:0]  n_pwdata, n_rdata;
    logic [SW-1:0]  n_pwstrb;
    logic [2:0]     n_pprot;
    logic [NIN-1:0] n_ack, exp_grant;
    int             n_owner, n_last, pick;

    if (m_psel && m_pen) begin
      PREADY = (stall == 0);
      if (stall > 0) stall--;
    end else begin
      PREADY = 1'($urandom_range(0, 1));
    end
    if (rand_slave) begin
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom_range(0, 1));
    end else begin
      PRDATA  = slv_rdata;
      PSLVERR = slv_err;
    end

    n_psel = m_psel; n_pen = m_pen; n_pwrite = m_pwrite; n_paddr = m_paddr;
    n_pwdata = m_pwdata; n_pwstrb = m_pwstrb; n_pprot = m_pprot;
    n_owner = m_owner; n_last = m_last;
    n_ack = '0; n_rdata = '0; n_err = 0;
    if (!m_psel) begin
      pick = -1;
      for (int k = 1; k <= NIN; k++) begin
        int c;
        c = (m_last + k) % NIN;
        if (pick < 0 && i_req[c] && !m_ack[c]) pick = c;
      end
      if (pick >= 0) begin
        n_psel   = 1; n_pen = 0;
        n_paddr  = i_addr[pick*AW +: AW];
        n_pwrite = i_write[pick];
        n_pwdata = i_wdata[pick*DW +: DW];
        n_pwstrb = i_write[pick] ? i_wstrb[pick*SW +: SW] : '0;
        n_pprot  = i_prot[pick*3 +: 3];
        n_owner  = pick;
        n_last   = pick;
      end
    end else if (!m_pen) begin
      n_pen = 1;
    end else if (PREADY) begin
      n_ack[m_owner] = 1'b1;
      n_rdata = m_pwrite ? '0 : PRDATA;
      n_err   = PSLVERR;
      n_psel  = 0; n_pen = 0; n_owner = -1;
    end

    @(posedge PCLK); #1;

    m_psel = n_psel; m_pen = n_pen; m_pwrite = n_pwrite; m_paddr = n_paddr;
    m_pwdata = n_pwdata; m_pwstrb = n_pwstrb; m_pprot = n_pprot;
    m_owner = n_owner; m_last = n_last; m_ack = n_ack; m_rdata = n_rdata; m_err = n_err;

    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    chk("psel",    PSEL,    m_psel);
    chk("penable", PENABLE, m_pen);
    chk("grant",   o_grant, exp_grant);
    chk("ack",     o_ack,   m_ack);
    chk("rdata",   o_rdata, m_rdata);
    chk("err",     o_err,   m_err);
    if (m_psel) begin
      chk("paddr",  PADDR,  m_paddr);
      chk("pwrite", PWRITE, m_pwrite);
      chk("pwdata", PWDATA, m_pwdata);
      chk("pwstrb", PWSTRB, m_pwstrb);
      chk("pprot",  PPROT,  m_pprot);
    end

    if (o_grant != '0 && prev_grant == '0) begin
      gq.push_back(o_grant);
      gapq.push_back(idle_run);
    end
    prev_grant = o_grant;
    idle_run   = PSEL ? 0 : idle_run + 1;

    for (int i = 0; i < NIN; i++) begin
      if (m_ack[i]) begin
        if (remaining[i] > 0) begin
          remaining[i]--;
          rand_payload(i);
        end else begin
          i_req[i] = 1'b0;
        end
      end
    end
    if (m_psel && !m_pen) begin
      if (scramble) rand_payload(m_owner);
      if (rand_slave) stall = $urandom_range(0, 3);
    end
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while ((i_req != '0 || m_psel || m_ack != '0) && b < budget) begin
      step();
      b++;
    end
    chk("drain_within_budget", 64'(b < budget), 64'(1));
  endtask

  task automatic reset_all();
    PRESETn = 1'b0;
    model_reset();
    for (int i = 0; i < NIN; i++) remaining[i] = 0;
    i_req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    i_req = '0; i_addr = '0; i_write = '0; i_wdata = '0; i_wstrb = '0; i_prot = '0;
    PREADY = 0; PSLVERR = 0; PRDATA = '0;
    stall = 0; rand_slave = 0; scramble = 0; slv_rdata = '0; slv_err = 0;
    idle_run = 0; prev_grant = '0;
    reset_all();

    // Reset values.
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_psel",  PSEL, 0);
    chk("rst_pen",   PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_ack",   o_ack, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_rdata", o_rdata, 0);
    PRESETn = 1'b1;

    // Single read with zero wait states.
    slv_rdata = 32'hDEAD_BEEF; slv_err = 0; stall = 0;
    issue(0, 32'h40, 1'b0, 32'h5555_AAAA, 4'hF, 3'd2, 0);
    step();
    chk("t1_psel", PSEL, 1);
    chk("t1_pen0", PENABLE, 0);
    chk("t1_paddr", PADDR, 32'h40);
    chk("t1_pwstrb_read", PWSTRB, 0);
    step();
    chk("t1_pen1", PENABLE, 1);
    step();
    chk("t1_ack", o_ack, 2'b01);
    chk("t1_rdata", o_rdata, 32'hDEAD_BEEF);
    chk("t1_err", o_err, 0);
    step();
    chk("t1_ack_clear", o_ack, 0);
    drain(20);

    // Stalled write from requester 1.
    stall = 3;
    issue(1, 32'h8, 1'b1, 32'h1234_5678, 4'hF, 3'd0, 0);
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      step();
      chk("t2_stall_paddr", PADDR, 32'h8);
      chk("t2_stall_pwdata", PWDATA, 32'h1234_5678);
      chk("t2_stall_pwstrb", PWSTRB, 4'hF);
      chk("t2_stall_psel", {PSEL, PENABLE}, 2'b11);
      chk("t2_stall_noack", o_ack, 0);
    end
    step();
    chk("t2_ack", o_ack, 2'b10);
    chk("t2_rdata_write", o_rdata, 0);
    drain(20);

    // Contention from reset: four transfers each, alternating grants.
    reset_all();
    stall = 0;
    issue(0, 32'h100, 1'b0, 32'h0, 4'h0, 3'd0, 3);
    issue(1, 32'h200, 1'b1, 32'h1, 4'h3, 3'd1, 3);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    gq.delete(); gapq.delete(); prev_grant = '0; idle_run = 0;
    drain(100);
    chk("t3_count", gq.size(), 8);
    for (int k = 0; k < gq.size(); k++) begin
      chk("t3_order", gq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) chk("t3_gap", gapq[k], 1);
    end

    // Sole requester held continuously: the acked requester is masked during
    // its ack cycle, so the gap is the ack cycle plus the masked pick cycle.
    gq.delete(); gapq.delete();
    issue(0, 32'h300, 1'b0, 32'h0, 4'h0, 3'd0, 3);
    drain(100);
    chk("t4_count", gq.size(), 4);
    for (int k = 0; k < gq.size(); k++) begin
      chk("t4_owner", gq[k], 2'b01);
      if (k > 0) chk("t4_gap", gapq[k], 2);
    end

    // Slave error then a clean transfer.
    slv_err = 1; slv_rdata = 32'hCAFE_0001; stall = 0;
    issue(0, 32'h44, 1'b0, 32'h0, 4'h0, 3'd0, 1);
    step(); step(); step();
    chk("t5_ack", o_ack, 2'b01);
    chk("t5_err", o_err, 1);
    slv_err = 0;
    step(); step(); step(); step();
    chk("t5_ack2", o_ack, 2'b01);
    chk("t5_err2", o_err, 0);
    drain(20);

    // Asynchronous reset while stalled in the access phase.
    stall = 10;
    issue(0, 32'h50, 1'b1, 32'hA5A5_A5A5, 4'h9, 3'd3, 0);
    step(); step(); step();
    chk("t6_pre", {PSEL, PENABLE}, 2'b11);
    #2;
    reset_all();
    #1;
    chk("t6_psel", PSEL, 0);
    chk("t6_pen", PENABLE, 0);
    chk("t6_pwrite", PWRITE, 0);
    chk("t6_paddr", PADDR, 0);
    chk("t6_pwdata", PWDATA, 0);
    chk("t6_pwstrb", PWSTRB, 0);
    chk("t6_pprot", PPROT, 0);
    chk("t6_ack", o_ack, 0);
    chk("t6_grant", o_grant, 0);
    chk("t6_rdata", o_rdata, 0);
    chk("t6_err", o_err, 0);
    rand_payload(0); rand_payload(1);
    i_req = '1;
    @(posedge PCLK); #1;
    chk("t6_hold_ack", o_ack, 0);
    chk("t6_hold_psel", PSEL, 0);
    PRESETn = 1'b1;
    stall = 0;
    step();
    chk("t6_prio", o_grant, 2'b01);
    drain(40);

    // Random traffic: random payloads, stalls, slave responses, payload churn after grant.
    rand_slave = 1; scramble = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NIN; i++) begin
        if (!i_req[i] && $urandom_range(0, 3) == 0) begin
          rand_payload(i);
          i_req[i] = 1'b1;
          remaining[i] = 0;
        end
      end
      step();
    end
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
